// File: rtl/asteroid_sprite_if.sv
// ============================================================================
// Module   : asteroid_sprite_if
// Brief    : Pixel-timing inputs and per-pixel/lifecycle outputs of the sprite.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface asteroid_sprite_if;
  logic       pix_en;
  logic [9:0] HCounter;
  logic [9:0] VCounter;
  logic       hit_in;
  logic       pixel_on;
  logic       destroyed;
  logic       ground_hit;
  logic       falling;

  modport master (
    output pix_en, HCounter, VCounter, hit_in,
    input  pixel_on, destroyed, ground_hit, falling
  );

  modport slave (
    input  pix_en, HCounter, VCounter, hit_in,
    output pixel_on, destroyed, ground_hit, falling
  );
endinterface

`default_nettype wire

// File: rtl/asteroid_sprite.sv
// ============================================================================
// Module   : asteroid_sprite
// Brief    : One falling asteroid: spawn, fall, explode on hit/ground, respawn.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module asteroid_sprite #(
  parameter int            SIZE           = 16,
  parameter int            SPEED          = 2,
  parameter int            H_MIN          = 144,
  parameter int            H_MAX          = 783,
  parameter int            V_MIN          = 36,
  parameter int            V_GROUND       = 480,
  parameter int            EXPLODE_FRAMES = 16,
  parameter int            RESPAWN_FRAMES = 4,
  parameter logic [9:0]    LFSR_SEED      = 10'h2A5
) (
  input  logic              clk,
  input  logic              reset,
  asteroid_sprite_if.slave  bus
);

  localparam logic [1:0] c_wait    = 2'd0;
  localparam logic [1:0] c_fall    = 2'd1;
  localparam logic [1:0] c_explode = 2'd2;

  localparam int         c_span     = H_MAX - H_MIN + 1 - SIZE;
  localparam logic [7:0] c_wait_end = 8'(RESPAWN_FRAMES - 1);
  localparam logic [7:0] c_exp_end  = 8'(EXPLODE_FRAMES - 1);

  logic [1:0] r_state;
  logic [7:0] r_wait_cnt;
  logic [7:0] r_exp_cnt;
  logic [9:0] r_x;
  logic [9:0] r_y;
  logic [9:0] r_lfsr;
  logic       r_hit_pending;
  logic       r_destroyed;
  logic       r_ground_hit;
  logic       r_falling;

  logic       w_frame_tick;
  logic [9:0] w_off;
  logic [9:0] w_spawn_x;
  logic [9:0] w_y_next;
  logic       w_ground;
  logic       w_in_box;

  assign w_frame_tick = bus.pix_en && (bus.HCounter == 10'd799) && (bus.VCounter == 10'd524);

  // Folding offsets past the visible span back by 512 keeps the whole box on screen.
  assign w_off     = (r_lfsr > 10'(c_span)) ? (r_lfsr - 10'd512) : r_lfsr;
  assign w_spawn_x = 10'(H_MIN) + w_off;

  assign w_y_next = r_y + 10'(SPEED);
  assign w_ground = (w_y_next + 10'(SIZE)) >= 10'(V_GROUND);

  assign w_in_box = (bus.HCounter >= r_x) && (bus.HCounter < (r_x + 10'(SIZE))) &&
                    (bus.VCounter >= r_y) && (bus.VCounter < (r_y + 10'(SIZE)));

  always_comb begin
    bus.pixel_on = 1'b0;
    case (r_state)
      c_fall:    bus.pixel_on = w_in_box;
      c_explode: bus.pixel_on = w_in_box && !r_exp_cnt[1];
      default:   bus.pixel_on = 1'b0;
    endcase
  end

  assign bus.destroyed  = r_destroyed;
  assign bus.ground_hit = r_ground_hit;
  assign bus.falling    = r_falling;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= c_wait;
      r_wait_cnt    <= 8'd0;
      r_exp_cnt     <= 8'd0;
      r_x           <= 10'(H_MIN);
      r_y           <= 10'(V_MIN);
      r_lfsr        <= LFSR_SEED;
      r_hit_pending <= 1'b0;
      r_destroyed   <= 1'b0;
      r_ground_hit  <= 1'b0;
      r_falling     <= 1'b0;
    end else begin
      r_destroyed  <= 1'b0;
      r_ground_hit <= 1'b0;

      if (w_frame_tick) begin
        r_lfsr <= {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};
      end

      case (r_state)
        c_wait: begin
          if (w_frame_tick) begin
            if (r_wait_cnt == c_wait_end) begin
              r_x           <= w_spawn_x;
              r_y           <= 10'(V_MIN);
              r_wait_cnt    <= 8'd0;
              r_hit_pending <= 1'b0;
              r_state       <= c_fall;
              r_falling     <= 1'b1;
            end else begin
              r_wait_cnt <= r_wait_cnt + 8'd1;
            end
          end
        end

        c_fall: begin
          if (w_frame_tick) begin
            // A latched shot takes priority over ground contact on the same frame.
            if (r_hit_pending) begin
              r_destroyed   <= 1'b1;
              r_exp_cnt     <= 8'd0;
              r_hit_pending <= 1'b0;
              r_state       <= c_explode;
              r_falling     <= 1'b0;
            end else begin
              r_y           <= w_y_next;
              r_hit_pending <= bus.hit_in;
              if (w_ground) begin
                r_ground_hit <= 1'b1;
                r_exp_cnt    <= 8'd0;
                r_state      <= c_explode;
                r_falling    <= 1'b0;
              end
            end
          end else if (bus.hit_in) begin
            r_hit_pending <= 1'b1;
          end
        end

        c_explode: begin
          if (w_frame_tick) begin
            if (r_exp_cnt == c_exp_end) begin
              r_exp_cnt <= 8'd0;
              r_state   <= c_wait;
            end else begin
              r_exp_cnt <= r_exp_cnt + 8'd1;
            end
          end
        end

        default: begin
          r_state   <= c_wait;
          r_falling <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_asteroid_sprite.sv
// ============================================================================
// Module   : tb_asteroid_sprite
// Brief    : Randomized self-checking bench against a frame-level asteroid model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_asteroid_sprite;

  logic clk = 1'b0;
  logic reset;

  asteroid_sprite_if bus();

  asteroid_sprite dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Frame-level model: mode 0 = waiting, 1 = falling, 2 = exploding.
  int m_mode, m_frames, m_x, m_y, m_lfsr;
  bit m_hit;
  int m_ed, m_eg;
  logic last_ds, last_gh;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_frames = 0; m_x = 144; m_y = 36; m_lfsr = 'h2A5; m_hit = 0;
  endtask

  function automatic int model_pixel(int h, int v);
    bit inside_box;
    inside_box = (h >= m_x) && (h < m_x + 16) && (v >= m_y) && (v < m_y + 16);
    if (m_mode == 1) return int'(inside_box);
    if (m_mode == 2) return int'(inside_box && ((m_frames % 4) < 2));
    return 0;
  endfunction

  task automatic model_tick();
    int old, off;
    m_ed = 0; m_eg = 0;
    old = m_lfsr;
    m_lfsr = ((old * 2) % 1024) | (((old >> 9) ^ (old >> 6)) & 1);
    case (m_mode)
      0: begin
        m_frames++;
        if (m_frames == 4) begin
          off = (old > 624) ? old - 512 : old;
          m_x = 144 + off; m_y = 36; m_frames = 0; m_hit = 0; m_mode = 1;
        end
      end
      1: begin
        if (m_hit) begin
          m_ed = 1; m_hit = 0; m_frames = 0; m_mode = 2;
        end else begin
          m_y += 2;
          if (m_y + 16 >= 480) begin m_eg = 1; m_frames = 0; m_mode = 2; end
        end
      end
      default: begin
        m_frames++;
        if (m_frames == 16) begin m_frames = 0; m_mode = 0; end
      end
    endcase
  endtask

  task automatic do_tick();
    int h, v;
    @(negedge clk);
    bus.pix_en = 1'b1; bus.HCounter = 10'd799; bus.VCounter = 10'd524; bus.hit_in = 1'b0;
    @(posedge clk); #1;
    model_tick();
    last_ds = bus.destroyed; last_gh = bus.ground_hit;
    check("destroyed", bus.destroyed, m_ed);
    check("ground_hit", bus.ground_hit, m_eg);
    check("falling", bus.falling, (m_mode == 1));
    @(negedge clk);
    h = $urandom_range(0, 798); v = $urandom_range(0, 524);
    bus.pix_en = 1'($urandom_range(0, 1)); bus.HCounter = 10'(h); bus.VCounter = 10'(v);
    #1 check("pixel_rand", bus.pixel_on, model_pixel(h, v));
    @(posedge clk); #1;
    check("pulse_len", {bus.destroyed, bus.ground_hit}, 0);
  endtask

  task automatic probe_exp(input string tag, input int h, input int v, input int exp);
    @(negedge clk);
    bus.HCounter = 10'(h); bus.VCounter = 10'(v); bus.pix_en = 1'($urandom_range(0, 1));
    #1 check(tag, bus.pixel_on, exp);
  endtask

  task automatic probe_box();
    probe_exp("box_tl", m_x, m_y, model_pixel(m_x, m_y));
    probe_exp("box_br", m_x + 15, m_y + 15, model_pixel(m_x + 15, m_y + 15));
    probe_exp("box_left", m_x - 1, m_y, model_pixel(m_x - 1, m_y));
    probe_exp("box_right", m_x + 16, m_y + 15, model_pixel(m_x + 16, m_y + 15));
    probe_exp("box_above", m_x, m_y - 1, model_pixel(m_x, m_y - 1));
    probe_exp("box_below", m_x + 7, m_y + 16, model_pixel(m_x + 7, m_y + 16));
  endtask

  task automatic hit_pulse();
    @(negedge clk);
    bus.hit_in = 1'b1; bus.pix_en = 1'b1; bus.HCounter = 10'd100; bus.VCounter = 10'd100;
    @(posedge clk); #1;
    if (m_mode == 1) m_hit = 1;
    @(negedge clk);
    bus.hit_in = 1'b0;
  endtask

  task automatic tick_until_y(input int target);
    int budget = 300;
    while (m_y != target && budget > 0) begin do_tick(); budget--; end
    if (budget == 0) check("timeout_y", 0, 1);
  endtask

  task automatic tick_until_mode(input int target);
    int budget = 400;
    while (m_mode != target && budget > 0) begin do_tick(); budget--; end
    if (budget == 0) check("timeout_mode", 0, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pixel"}, bus.pixel_on, 0);
    check({tag, "_destroyed"}, bus.destroyed, 0);
    check({tag, "_ground"}, bus.ground_hit, 0);
    check({tag, "_falling"}, bus.falling, 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.pix_en = 1'b0; bus.HCounter = 10'd144; bus.VCounter = 10'd36; bus.hit_in = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk) reset = 1'b0;

    // First spawn from the seed value lands at x=447, y=36.
    repeat (4) do_tick();
    check("spawn_falling", bus.falling, 1);
    probe_exp("spawn_in_tl", 447, 36, 1);
    probe_exp("spawn_left", 446, 36, 0);
    probe_exp("spawn_in_br", 462, 51, 1);
    probe_exp("spawn_right", 463, 51, 0);

    // Uninterrupted fall: ground contact on the 214th falling frame.
    for (int k = 1; k <= 214; k++) begin
      do_tick();
      if (k % 16 == 0) probe_box();
    end
    check("ground_at_214", last_gh, 1);
    check("ground_no_destroy", last_ds, 0);
    probe_exp("ground_y_top", 447, 464, 1);
    probe_exp("ground_y_above", 447, 463, 0);
    probe_exp("ground_y_bot", 462, 479, 1);
    probe_exp("ground_y_below", 447, 480, 0);

    // Explosion blink: visible for frames 0,1, dark for 2,3.
    for (int e = 0; e < 16; e++) begin
      if (e < 4) begin
        for (int v = 464; v < 480; v++)
          for (int h = 447; h < 463; h++)
            probe_exp("blink_scan", h, v, (e < 2) ? 1 : 0);
      end
      hit_pulse();
      do_tick();
    end
    check("wait_not_falling", bus.falling, 0);
    probe_exp("wait_dark", 447, 464, 0);

    // Shot mid-fall at y=100.
    tick_until_mode(1);
    tick_until_y(100);
    hit_pulse();
    do_tick();
    check("shot_destroyed", last_ds, 1);
    check("shot_no_ground", last_gh, 0);
    probe_exp("shot_y_hold", m_x, 100, 1);
    probe_exp("shot_y_above", m_x, 99, 0);
    tick_until_mode(0);

    // Shot latched in the frame where the ground would be reached.
    tick_until_mode(1);
    tick_until_y(462);
    hit_pulse();
    do_tick();
    check("tie_destroyed", last_ds, 1);
    check("tie_no_ground", last_gh, 0);

    // Randomized lifecycles with sporadic shots in any mode.
    for (int t = 0; t < 900; t++) begin
      if ($urandom_range(0, 49) == 0) hit_pulse();
      do_tick();
      if (t % 8 == 0) probe_box();
    end

    // Reset while falling drops everything at once.
    tick_until_mode(1);
    repeat (3) do_tick();
    probe_exp("pre_reset_pixel", m_x + 3, m_y + 3, 1);
    reset = 1'b1;
    #1 check_all_zero("reset_fall");
    model_reset();
    @(negedge clk) reset = 1'b0;

    // Reset at explosion frame 7, then the spawn sequence restarts from the seed.
    tick_until_mode(1);
    hit_pulse();
    do_tick();
    repeat (7) do_tick();
    @(negedge clk);
    bus.HCounter = 10'(m_x); bus.VCounter = 10'(m_y);
    reset = 1'b1;
    #1 check_all_zero("reset_explode");
    model_reset();
    @(negedge clk) reset = 1'b0;
    repeat (3) do_tick();
    check("respawn_wait", bus.falling, 0);
    do_tick();
    check("respawn_falling", bus.falling, 1);
    probe_exp("respawn_x_in", 447, 36, 1);
    probe_exp("respawn_x_left", 446, 36, 0);
    probe_exp("respawn_x_right", 463, 36, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/asteroid_sprite.md
Name: asteroid_sprite

Overview:
- Generates one falling asteroid object for the VGA display path.
- Consumes the pixel-rate H/V counters and pixel-clock enable produced by the horizontal/vertical timing stage.
- Produces a per-pixel "asteroid here" flag that the colour-mux stage ORs into Red/Green/Blue.
- Owns the asteroid lifecycle: spawn at a pseudo-random X, fall at fixed speed, explode on hit or ground contact, then respawn after a delay.

Parameters:
SIZE, 16, asteroid edge length in pixels (square)
SPEED, 2, rows moved per frame while falling
H_MIN, 144, first visible HCounter value
H_MAX, 783, last visible HCounter value
V_MIN, 36, spawn row (first visible VCounter value)
V_GROUND, 480, ground row; contact when y+SIZE >= V_GROUND
EXPLODE_FRAMES, 16, frames spent in EXPLODE
RESPAWN_FRAMES, 4, frames spent in WAIT before spawning
LFSR_SEED, 10'h2A5, reset value of spawn LFSR (must be nonzero)

Ports:
clk  input  1  system clock; the only clock
reset  input  1  asynchronous, active-high reset
pix_en  input  1  one-cycle pixel-clock enable, 1 per pixel
HCounter  input  10  current horizontal count, 0..799
VCounter  input  10  current vertical count, 0..524
hit_in  input  1  defense-shot collision, level or pulse, any cycle
pixel_on  output  1  asteroid covers current pixel (combinational from registered state)
destroyed  output  1  one-clk pulse: asteroid destroyed by shot
ground_hit  output  1  one-clk pulse: asteroid reached ground
falling  output  1  high while state == FALL

Behaviour:
- frame_tick = pix_en && HCounter==799 && VCounter==524. All position and state updates occur only on a frame_tick clk edge, except hit_pending.
- Reset (async): state=WAIT, wait_cnt=0, exp_cnt=0, x=H_MIN, y=V_MIN, lfsr=LFSR_SEED, hit_pending=0. destroyed=ground_hit=falling=pixel_on=0.
- LFSR: advances on every frame_tick in every state: lfsr <= {lfsr[8:0], lfsr[9]^lfsr[6]}.
- Spawn X: off = lfsr (pre-advance value). If off > (H_MAX-H_MIN+1-SIZE), i.e. > 624, then off = off-512. x = H_MIN + off (11-bit arithmetic, result always ≤ H_MAX-SIZE+1).
- WAIT:
  - On frame_tick: if wait_cnt == RESPAWN_FRAMES-1, load x, set y=V_MIN, wait_cnt=0, clear hit_pending, go to FALL.
  - Otherwise wait_cnt++.
- FALL:
  - hit_in==1 on any clk sets hit_pending.
  - On frame_tick, if hit_pending: pulse destroyed, y unchanged, exp_cnt=0, clear hit_pending, go to EXPLODE.
  - On frame_tick otherwise: y_next = y+SPEED. If y_next+SIZE >= V_GROUND: y=y_next, pulse ground_hit, exp_cnt=0, go to EXPLODE. Else y=y_next.
  - Shot and ground contact on the same tick: destroyed wins; ground_hit not asserted.
- EXPLODE:
  - hit_in is ignored.
  - On frame_tick: if exp_cnt == EXPLODE_FRAMES-1, exp_cnt=0 and go to WAIT. Else exp_cnt++.
- pixel_on:
  - In-box condition: HCounter in [x, x+SIZE-1] and VCounter in [y, y+SIZE-1].
  - FALL: pixel_on = in-box.
  - EXPLODE: pixel_on = in-box && exp_cnt[1]==0 (blink every 2 frames).
  - WAIT: pixel_on = 0.
  - pixel_on has zero latency relative to the counters.
- destroyed and ground_hit are registered, high for exactly one clk (the clk after the frame_tick edge), mutually exclusive.
- falling is registered; equals (state==FALL).
- Reset mid-frame or mid-EXPLODE: immediate return to reset values; no pulses emitted.

Test Plan:
- Reset, then run 4 frame_ticks -> FALL entered on tick 4 with x=447 (lfsr 0x12F=303 ≤ 624), y=36; falling=1.
- Continue falling with no hits -> y rises by 2 per frame. On the 214th FALL tick y=464: single ground_hit pulse, state EXPLODE, destroyed=0.
- In EXPLODE, scan the frame at H=447..462, V=464..479 -> pixel_on=1 for exp_cnt 0,1 and 0 for exp_cnt 2,3. After 16 ticks falling stays 0 and pixel_on=0 (WAIT).
- Pulse hit_in for 1 clk mid-frame while y=100 -> at next frame_tick destroyed pulses once, y stays 100, and ground_hit never fires.
- Assert hit_in in the same frame that y reaches 464 -> destroyed=1, ground_hit=0.
- Assert reset during EXPLODE at exp_cnt=7 -> all outputs 0 immediately. lfsr=0x2A5, and the next spawn x is again 447.
